// File: rtl/muldiv_cmd_sequencer.sv
// Command sequencer in front of the signed multiply/divide unit: queues operand
// commands, issues them one at a time, and returns results over valid/ready.
module muldiv_cmd_sequencer #(
   parameter int unsigned N       = 4,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         in_sel,
   input  logic [N-1:0]                 in_a,
   input  logic [N-1:0]                 in_b,
   output logic                         du_start,
   output logic                         du_sel,
   output logic [N-1:0]                 du_a,
   output logic [N-1:0]                 du_b,
   input  logic                         du_busy,
   input  logic                         du_valid,
   input  logic                         du_error,
   input  logic [N-1:0]                 du_m,
   input  logic [N-1:0]                 du_r,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         out_sel,
   output logic [N-1:0]                 out_m,
   output logic [N-1:0]                 out_r,
   output logic                         out_error,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned WW = $clog2(TIMEOUT + 1);

   typedef struct packed {
      logic         sel;
      logic [N-1:0] a;
      logic [N-1:0] b;
   } cmd_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t         state, state_d;
   cmd_t           mem [DEPTH];
   cmd_t           in_cmd;
   cmd_t           head;
   logic [AW-1:0]  wr_ptr, wr_ptr_d, rd_ptr, rd_ptr_d;
   logic [CW-1:0]  count_d;
   logic           in_ready_d;
   logic           push, pop;
   logic [WW-1:0]  wd, wd_d;
   logic           du_start_d, du_sel_d;
   logic [N-1:0]   du_a_d, du_b_d;
   logic           out_valid_d, out_sel_d, out_error_d;
   logic [N-1:0]   out_m_d, out_r_d;

   // Command FIFO storage; contents need no reset since pointers define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_cmd;
      end
   end

   // FIFO pointer and occupancy next-state.
   always_comb begin
      in_cmd     = '{sel: in_sel, a: in_a, b: in_b};
      head       = mem[rd_ptr];
      push       = in_valid & in_ready;
      wr_ptr_d   = push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr_d   = pop  ? rd_ptr + AW'(1) : rd_ptr;
      count_d    = count;
      case ({push, pop})
         2'b10:   count_d = count + CW'(1);
         2'b01:   count_d = count - CW'(1);
         default: count_d = count;
      endcase
      in_ready_d = (count_d != CW'(DEPTH));
   end

   // Sequencer next-state and registered-output next values.
   always_comb begin
      state_d     = state;
      pop         = 1'b0;
      wd_d        = wd;
      du_start_d  = 1'b0;
      du_sel_d    = du_sel;
      du_a_d      = du_a;
      du_b_d      = du_b;
      out_valid_d = out_valid;
      out_sel_d   = out_sel;
      out_m_d     = out_m;
      out_r_d     = out_r;
      out_error_d = out_error;
      case (state)
         IDLE: begin
            if (count != '0) begin
               if (!head.sel && (head.b == '0)) begin
                  // Divide-by-zero is answered locally without touching the unit.
                  pop         = 1'b1;
                  out_valid_d = 1'b1;
                  out_sel_d   = 1'b0;
                  out_m_d     = '0;
                  out_r_d     = '0;
                  out_error_d = 1'b1;
                  state_d     = HOLD;
               end else if (!du_busy) begin
                  pop        = 1'b1;
                  du_start_d = 1'b1;
                  du_sel_d   = head.sel;
                  du_a_d     = head.a;
                  du_b_d     = head.b;
                  wd_d       = '0;
                  state_d    = WAIT;
               end
            end
         end
         WAIT: begin
            wd_d = wd + WW'(1);
            // du_start high marks the issue cycle, where responses are not yet sampled.
            if (!du_start && (du_valid || du_error)) begin
               out_valid_d = 1'b1;
               out_sel_d   = du_sel;
               out_m_d     = du_m;
               out_r_d     = du_r;
               out_error_d = du_error;
               state_d     = HOLD;
            end else if (wd_d == WW'(TIMEOUT)) begin
               out_valid_d = 1'b1;
               out_sel_d   = du_sel;
               out_m_d     = '0;
               out_r_d     = '0;
               out_error_d = 1'b1;
               state_d     = HOLD;
            end
         end
         HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         in_ready  <= 1'b1;
         wd        <= '0;
         du_start  <= 1'b0;
         du_sel    <= 1'b0;
         du_a      <= '0;
         du_b      <= '0;
         out_valid <= 1'b0;
         out_sel   <= 1'b0;
         out_m     <= '0;
         out_r     <= '0;
         out_error <= 1'b0;
      end else begin
         wr_ptr    <= wr_ptr_d;
         rd_ptr    <= rd_ptr_d;
         count     <= count_d;
         in_ready  <= in_ready_d;
         wd        <= wd_d;
         du_start  <= du_start_d;
         du_sel    <= du_sel_d;
         du_a      <= du_a_d;
         du_b      <= du_b_d;
         out_valid <= out_valid_d;
         out_sel   <= out_sel_d;
         out_m     <= out_m_d;
         out_r     <= out_r_d;
         out_error <= out_error_d;
      end
   end

endmodule

// File: tb/tb_muldiv_cmd_sequencer.sv
// Scoreboard bench for muldiv_cmd_sequencer with a stub multiply/divide unit.
module tb_muldiv_cmd_sequencer;

   localparam int unsigned N       = 4;
   localparam int unsigned DEPTH   = 4;
   localparam int unsigned TIMEOUT = 16;
   localparam int unsigned CW      = $clog2(DEPTH + 1);

   logic          clk, rst;
   logic          in_valid, in_ready, in_sel;
   logic [N-1:0]  in_a, in_b;
   logic          du_start, du_sel, du_busy, du_valid, du_error;
   logic [N-1:0]  du_a, du_b, du_m, du_r;
   logic          out_valid, out_ready, out_sel, out_error;
   logic [N-1:0]  out_m, out_r;
   logic [CW-1:0] count;

   muldiv_cmd_sequencer #(.N(N), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_a(in_a), .in_b(in_b),
      .du_start(du_start), .du_sel(du_sel), .du_a(du_a), .du_b(du_b),
      .du_busy(du_busy), .du_valid(du_valid), .du_error(du_error), .du_m(du_m), .du_r(du_r),
      .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel),
      .out_m(out_m), .out_r(out_r), .out_error(out_error), .count(count)
   );

   // Stub behaviour for one issued command, decided when the command is accepted.
   typedef struct {
      logic         sel;
      logic [N-1:0] a, b;
      logic         silent, err, vflag;
      int           dly;
      logic [N-1:0] m, r;
   } plan_t;

   // Expected returned result; kind 0 = unit response, 1 = local div-by-zero, 2 = timeout.
   typedef struct {
      logic         sel;
      logic [N-1:0] m, r;
      logic         err;
      int           kind;
   } exp_t;

   plan_t plan_q[$];
   exp_t  exp_q[$];

   int checks = 0, errors = 0;
   int cyc = 0;
   int start_cnt = 0, resp_cyc = 0, tmo_start = 0, accept_cyc = 0, rst_gen = 0;
   bit lat_check = 0, rand_mode = 0;
   logic busy_force = 0, ready_force = 1;

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not end, cycle=%0d", cyc);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference arithmetic: full signed product, or truncating quotient and remainder.
   function automatic logic [2*N-1:0] ref_op(input logic sel, input logic [N-1:0] a,
                                             input logic [N-1:0] b);
      int x, y;
      logic [2*N-1:0] res;
      x = int'($signed(a));
      y = int'($signed(b));
      if (sel) begin
         res = (2*N)'(x * y);
      end else begin
         res[2*N-1:N] = N'(x / y);
         res[N-1:0]   = N'(x % y);
      end
      return res;
   endfunction

   // Record a command the DUT is about to accept: stub plan plus expected result.
   task automatic model_accept(input logic sel, input logic [N-1:0] a, input logic [N-1:0] b,
                               input int pk, input int dly, input bit echo);
      plan_t p;
      logic [2*N-1:0] mr;
      accept_cyc = cyc;
      if (!sel && b == '0) begin
         exp_q.push_back('{sel: 1'b0, m: '0, r: '0, err: 1'b1, kind: 1});
      end else begin
         p.sel = sel; p.a = a; p.b = b; p.dly = dly;
         p.silent = (pk == 2);
         p.err    = (pk == 1);
         p.vflag  = 1'($urandom);
         if (pk == 1) begin
            p.m = N'($urandom); p.r = N'($urandom);
         end else if (echo) begin
            p.m = '0; p.r = a;
         end else begin
            mr = ref_op(sel, a, b);
            p.m = mr[2*N-1:N]; p.r = mr[N-1:0];
         end
         plan_q.push_back(p);
         if (p.silent)
            exp_q.push_back('{sel: sel, m: '0, r: '0, err: 1'b1, kind: 2});
         else
            exp_q.push_back('{sel: sel, m: p.m, r: p.r, err: p.err, kind: 0});
      end
   endtask

   // Offer one command and wait (bounded) for acceptance.
   task automatic send(input logic sel, input logic [N-1:0] a, input logic [N-1:0] b,
                       input int pk, input int dly, input bit echo);
      int waitc = 0;
      in_valid = 1; in_sel = sel; in_a = a; in_b = b;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         waitc++;
         if (waitc > 500) begin
            checks++; errors++;
            $display("FAIL send_accept: in_ready stuck at 0 expected 1 (cycle %0d)", cyc);
            in_valid = 0;
            return;
         end
      end
      model_accept(sel, a, b, pk, dly, echo);
      @(posedge clk); #1;
      in_valid = 0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(posedge clk); n++;
      end
      if (exp_q.size() != 0) begin
         checks++; errors++;
         $display("FAIL drain: %0d results outstanding expected 0", exp_q.size());
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   // Environment drivers for du_busy and out_ready.
   initial begin
      du_busy = 0; out_ready = 1;
      forever begin
         @(posedge clk); #1;
         du_busy   = rand_mode ? ($urandom % 4 == 0) : busy_force;
         out_ready = rand_mode ? ($urandom % 3 != 0) : ready_force;
      end
   end

   // Stub unit: answers each issue according to the plan queued at accept time.
   initial begin
      plan_t p;
      int    gen, ts;
      du_valid = 0; du_error = 0; du_m = '0; du_r = '0;
      forever begin
         @(posedge clk); #1;
         if (!rst && du_start) begin
            if (plan_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_issue: du_start=1 expected 0 (cycle %0d)", cyc);
            end else begin
               p = plan_q.pop_front();
               gen = rst_gen;
               ts = cyc;
               if (lat_check) begin
                  chk("start_latency", 32'(cyc - accept_cyc), 32'd2);
                  lat_check = 0;
               end
               chk("issue_ops", {29'd0, du_sel, du_a, du_b} & 32'h1FF, {23'd0, p.sel, p.a, p.b});
               if (p.silent) begin
                  tmo_start = ts;
               end else begin
                  repeat (p.dly) @(posedge clk);
                  #1;
                  if (gen == rst_gen)
                     chk("du_hold", {23'd0, du_sel, du_a, du_b}, {23'd0, p.sel, p.a, p.b});
                  du_valid = p.err ? p.vflag : 1'b1;
                  du_error = p.err;
                  du_m = p.m; du_r = p.r;
                  resp_cyc = cyc;
                  @(posedge clk); #1;
                  du_valid = 0; du_error = 0; du_m = N'($urandom); du_r = N'($urandom);
               end
            end
         end
      end
   end

   // Monitor: pops the scoreboard on each output handshake; checks stability and timing.
   initial begin
      exp_t e;
      logic prev_valid = 0, prev_ready = 0, prev_start = 0;
      logic [2*N+1:0] held = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_valid = 0; prev_ready = 0; prev_start = 0;
            continue;
         end
         if (du_start) begin
            start_cnt++;
            chk("start_pulse", 32'(prev_start), 32'd0);
         end
         prev_start = du_start;
         if (out_valid && prev_valid && !prev_ready)
            chk("out_stable", 32'({out_sel, out_error, out_m, out_r}), 32'(held));
         if (out_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_output: out_valid=1 expected 0 (cycle %0d)", cyc);
            end else begin
               e = exp_q[0];
               if (e.kind == 0) chk("resp_latency", 32'(cyc - resp_cyc), 32'd1);
               if (e.kind == 2) chk("tmo_latency", 32'(cyc - tmo_start), 32'(TIMEOUT));
            end
         end
         if (out_valid && out_ready && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("out_error", 32'(out_error), 32'(e.err));
            chk("out_m", 32'(out_m), 32'(e.m));
            chk("out_r", 32'(out_r), 32'(e.r));
            if (e.kind != 2) chk("out_sel", 32'(out_sel), 32'(e.sel));
         end
         held = {out_sel, out_error, out_m, out_r};
         prev_valid = out_valid;
         prev_ready = out_ready;
      end
   end

   // Main stimulus sequence.
   initial begin
      int s0, acc, n;
      rst = 1; in_valid = 0; in_sel = 0; in_a = '0; in_b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_du_start", 32'(du_start), 32'd0);
      chk("rst_out_error", 32'(out_error), 32'd0);
      chk("rst_out_data", 32'({out_m, out_r}), 32'd0);
      @(posedge clk); #1;
      rst = 0;
      repeat (2) @(posedge clk);
      #1;

      // Multiply with start-latency check.
      lat_check = 1;
      send(1'b1, 4'd5, 4'd2, 0, 3, 0);
      drain();

      // Divide.
      send(1'b0, 4'd6, 4'd2, 0, 4, 0);
      drain();

      // Divide-by-zero while the unit is busy.
      busy_force = 1;
      @(posedge clk); #1;
      s0 = start_cnt;
      send(1'b0, 4'd7, 4'd0, 0, 2, 0);
      drain();
      chk("div0_no_start", 32'(start_cnt - s0), 32'd0);

      // FIFO fill while the unit is busy.
      @(posedge clk); #1;
      acc = 0;
      for (int i = 1; i <= 6; i++) begin
         in_valid = 1; in_sel = 1; in_a = N'(i); in_b = 4'd1;
         @(negedge clk);
         if (in_ready) begin
            acc++;
            model_accept(1'b1, N'(i), 4'd1, 0, 2, 1);
         end
         @(posedge clk); #1;
      end
      in_valid = 0;
      @(negedge clk);
      chk("fill_accepted", 32'(acc), 32'd4);
      chk("fill_count", 32'(count), 32'(DEPTH));
      chk("fill_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      busy_force = 0;
      drain();

      // Timeout followed by a normal command.
      send(1'b1, 4'd3, 4'd3, 2, 1, 0);
      send(1'b1, 4'd2, 4'd7, 0, 5, 0);
      drain();

      // Backpressure.
      ready_force = 0;
      send(1'b1, 4'd9, 4'd6, 0, 2, 0);
      n = 0;
      while (!out_valid && n < 100) begin
         @(posedge clk); #1; n++;
      end
      chk("bp_valid", 32'(out_valid), 32'd1);
      repeat (10) @(posedge clk);
      #1;
      ready_force = 1;
      drain();

      // Reset during WAIT with another command queued; the stub then answers stale.
      s0 = start_cnt;
      send(1'b1, 4'd4, 4'd4, 0, 12, 0);
      send(1'b0, 4'd5, 4'd3, 0, 12, 0);
      n = 0;
      while (start_cnt == s0 && n < 100) begin
         @(posedge clk); #1; n++;
      end
      chk("rst_test_issued", 32'(start_cnt - s0), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      rst = 1;
      rst_gen++;
      exp_q.delete();
      plan_q.delete();
      @(posedge clk); #1;
      rst = 0;
      @(negedge clk);
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_du_start", 32'(du_start), 32'd0);
      chk("mid_rst_count", 32'(count), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      repeat (30) @(posedge clk);
      @(negedge clk);
      chk("stray_no_output", 32'(out_valid), 32'd0);
      @(posedge clk); #1;

      // Randomized traffic against the reference model.
      rand_mode = 1;
      for (int i = 0; i < 200; i++) begin
         logic         rs;
         logic [N-1:0] ra, rb;
         int           r, pk;
         repeat ($urandom % 3) @(posedge clk);
         #1;
         rs = 1'($urandom);
         ra = N'($urandom);
         rb = N'($urandom);
         if ($urandom % 8 == 0) rb = '0;
         r  = int'($urandom % 16);
         pk = (r == 0) ? 2 : (r < 3) ? 1 : 0;
         send(rs, ra, rb, pk, int'($urandom_range(1, 15)), 0);
      end
      drain();
      rand_mode = 0;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
